// File: rtl/lab_pkg.sv
// Shared constants and per-channel state encoding for the input debouncer.
// The optional latching-toggle mode is selected by INPUT_DEBOUNCER_TOGGLE_EN.
package lab_pkg;

    // Default debounce lengths: short for simulation, 5 ms at 100 MHz for the board.
    localparam int unsigned DebounceCyclesSim   = 4;
    localparam int unsigned DebounceCyclesBoard = 500000;

    // STABLE: synchronised input agrees with the clean level; COUNTING otherwise.
    typedef enum logic {
        StStable   = 1'b0,
        StCounting = 1'b1
    } deb_state_e;

    // Counter width able to hold DEBOUNCE_CYCLES-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single debounce channel: two-flop synchroniser, stability counter, clean level and
// registered rise/fall pulses. With INPUT_DEBOUNCER_TOGGLE_EN defined, clean_out
// instead drives a toggle register that flips on every debounced rising edge.
module debounce_ch
    import lab_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesBoard
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    deb_state_e       state;

    assign state = (s2_q == level_q) ? StStable : StCounting;

    // Count consecutive disagreeing cycles; commit the new level on the last one.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (state == StCounting) begin
            if (cnt_q == CntLast) begin
                level_d = s2_q;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, counter, level and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw_in;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef INPUT_DEBOUNCER_TOGGLE_EN
    logic toggle_q, toggle_d;

    // Flip one cycle after each debounced press so a push-button latches.
    always_comb begin
        toggle_d = toggle_q ^ rise_q;
    end

    // Toggle register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign clean_out = toggle_q;
`else
    assign clean_out = level_q;
`endif

    a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n) !(rise_q && fall_q));
    a_cnt_range:  assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CntLast);
    a_stable_clr: assert property (@(posedge clk) disable iff (!rst_n)
                                   (state == StStable) |=> (cnt_q == '0));

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel switch/button conditioner: N_CH independent debounce_ch instances.
// Define INPUT_DEBOUNCER_TOGGLE_EN to turn every channel into a latching toggle.
module input_debouncer
    import lab_pkg::*;
#(
    parameter int unsigned N_CH            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesBoard
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw_in    (raw_in[i]),
            .clean_out (clean_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i])
        );
    end

endmodule
